// File: rtl/id_queue_stage.sv
// id_queue_stage
// ---------------------------------------------------------------------------
// Decode stage sitting between the instruction-memory response and EX.
// Fetched {pc, inst} pairs are buffered in a DEPTH-entry circular queue; the
// head entry is decoded and registered into a single output slot that EX
// consumes with a valid/ready handshake.
//
// Handshake semantics: a transfer from the slot to EX happens on every rising
// clk edge where out_valid && ex_ready. While out_valid && !ex_ready the slot
// contents are held bit-stable. On the fetch side, a response is accepted on
// every edge where imem_resp && fetch_ready; fetch_ready depends only on the
// registered queue occupancy, so it never combinationally follows ex_ready.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   imem_rdata, fetch_pc, imem_resp   fetched instruction, its PC, valid strobe
//   fetch_ready         queue has a free entry for the next edge
//   flush               synchronous kill of queue and slot (highest priority)
//   ex_ready            EX accepts the slot this cycle
//   out_valid, out_pc, out_inst        slot valid, PC and raw instruction
//   out_opcode/funct3/funct7/rs1_s/rs2_s/rd_s   decoded register/opcode fields
//   out_i/s/b/u/j_imm   sign-extended RV32I immediates
//   out_illegal         opcode is not a legal RV32I encoding (ILLEGAL_CHECK=1)
//   overflow_err        sticky: a response arrived while the queue was full
// ---------------------------------------------------------------------------
module id_queue_stage #(
    parameter int DEPTH         = 4,
    parameter bit ILLEGAL_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [4:0]  out_rs1_s,
    output logic [4:0]  out_rs2_s,
    output logic [4:0]  out_rd_s,
    output logic [31:0] out_i_imm,
    output logic [31:0] out_s_imm,
    output logic [31:0] out_b_imm,
    output logic [31:0] out_u_imm,
    output logic [31:0] out_j_imm,
    output logic        out_illegal,
    output logic        overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
        logic        illegal;
    } slot_t;

    function automatic slot_t decode(input logic [31:0] pc, input logic [31:0] ins);
        slot_t s;
        logic  legal;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        s.pc      = pc;
        s.inst    = ins;
        s.opcode  = ins[6:0];
        s.funct3  = ins[14:12];
        s.funct7  = ins[31:25];
        s.rs1     = ins[19:15];
        s.rs2     = ins[24:20];
        s.rd      = ins[11:7];
        s.i_imm   = {{20{ins[31]}}, ins[31:20]};
        s.s_imm   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        s.b_imm   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        s.u_imm   = {ins[31:12], 12'h000};
        s.j_imm   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        s.illegal = ILLEGAL_CHECK ? (!legal || (ins[1:0] != 2'b11)) : 1'b0;
        return s;
    endfunction

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    slot_t         slot_q, slot_d;
    logic          push, load, empty;

    assign fetch_ready = (count_q != CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign push        = imem_resp && fetch_ready && !flush;
    // The slot refills whenever it is empty or being consumed this edge.
    assign load        = !empty && (!valid_q || ex_ready) && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        slot_d  = slot_q;
        if (flush) begin
            // Slot data is left stale; only the valid bit matters.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (imem_resp && !fetch_ready) ovf_d = 1'b1;
            if (push) tail_d = tail_q + PW'(1);
            if (load) begin
                head_d  = head_q + PW'(1);
                slot_d  = decode(pc_mem[head_q], inst_mem[head_q]);
                valid_d = 1'b1;
            end else if (ex_ready) begin
                valid_d = 1'b0;
            end
            case ({push, load})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            slot_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            slot_q  <= slot_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= fetch_pc;
            inst_mem[tail_q] <= imem_rdata;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = slot_q.pc;
    assign out_inst     = slot_q.inst;
    assign out_opcode   = slot_q.opcode;
    assign out_funct3   = slot_q.funct3;
    assign out_funct7   = slot_q.funct7;
    assign out_rs1_s    = slot_q.rs1;
    assign out_rs2_s    = slot_q.rs2;
    assign out_rd_s     = slot_q.rd;
    assign out_i_imm    = slot_q.i_imm;
    assign out_s_imm    = slot_q.s_imm;
    assign out_b_imm    = slot_q.b_imm;
    assign out_u_imm    = slot_q.u_imm;
    assign out_j_imm    = slot_q.j_imm;
    assign out_illegal  = slot_q.illegal;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_id_queue_stage.sv
module tb_id_queue_stage;

    localparam int DEPTH = 4;
    typedef logic [256:0] fv_t;

    logic        clk = 1'b0;
    logic        rst, imem_resp, flush, ex_ready;
    logic [31:0] imem_rdata, fetch_pc;

    logic        fetch_ready, out_valid, out_illegal, overflow_err;
    logic [31:0] out_pc, out_inst, out_i_imm, out_s_imm, out_b_imm, out_u_imm, out_j_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1_s, out_rs2_s, out_rd_s;

    logic        fetch_ready0, out_valid0, out_illegal0, overflow_err0;
    logic [31:0] out_pc0, out_inst0, out_i_imm0, out_s_imm0, out_b_imm0, out_u_imm0, out_j_imm0;
    logic [6:0]  out_opcode0, out_funct70;
    logic [2:0]  out_funct30;
    logic [4:0]  out_rs1_s0, out_rs2_s0, out_rd_s0;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [63:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_v   = 1'b0;
    bit          m_ovf = 1'b0;
    logic [6:0]  ops [12];

    always #5 clk = ~clk;

    id_queue_stage #(.DEPTH(DEPTH), .ILLEGAL_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .flush(flush), .ex_ready(ex_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rs1_s(out_rs1_s),
        .out_rs2_s(out_rs2_s), .out_rd_s(out_rd_s), .out_i_imm(out_i_imm),
        .out_s_imm(out_s_imm), .out_b_imm(out_b_imm), .out_u_imm(out_u_imm),
        .out_j_imm(out_j_imm), .out_illegal(out_illegal), .overflow_err(overflow_err)
    );

    id_queue_stage #(.DEPTH(DEPTH), .ILLEGAL_CHECK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .fetch_pc(fetch_pc), .fetch_ready(fetch_ready0), .flush(flush), .ex_ready(ex_ready),
        .out_valid(out_valid0), .out_pc(out_pc0), .out_inst(out_inst0), .out_opcode(out_opcode0),
        .out_funct3(out_funct30), .out_funct7(out_funct70), .out_rs1_s(out_rs1_s0),
        .out_rs2_s(out_rs2_s0), .out_rd_s(out_rd_s0), .out_i_imm(out_i_imm0),
        .out_s_imm(out_s_imm0), .out_b_imm(out_b_imm0), .out_u_imm(out_u_imm0),
        .out_j_imm(out_j_imm0), .out_illegal(out_illegal0), .overflow_err(overflow_err0)
    );

    // Reference decode, built from shifts of the raw word.
    function automatic fv_t ref_fields(input logic [31:0] pc, input logic [31:0] ins);
        logic signed [31:0] i_i, i_s, i_b, i_j;
        logic [31:0]        i_u;
        logic               ill;
        i_i = $signed(ins) >>> 20;
        i_s = $signed({ins[31:25], ins[11:7], 20'h0}) >>> 20;
        i_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 20'h0}) >>> 19;
        i_j = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 12'h0}) >>> 11;
        i_u = ins & 32'hFFFF_F000;
        ill = 1'b1;
        if (ins[1:0] == 2'b11 && (ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
            7'b0001111, 7'b1110011}))
            ill = 1'b0;
        return {pc, ins, ins[6:0], ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7],
                i_i, i_s, i_b, i_u, i_j, ill};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    // One clock cycle: scoreboard check at negedge, advance reference model,
    // then return 1 time unit after the rising edge.
    task automatic tick();
        fv_t         got, exp, got0;
        logic [63:0] e;
        bit          rdy, ld, acc;
        @(negedge clk);
        if (rst) begin
            n_cmp++;
            if ({fetch_ready, out_valid, overflow_err} !== {m_cnt != DEPTH, m_v, m_ovf}) begin
                n_err++;
                $display("FAIL status got=%b exp=%b", {fetch_ready, out_valid, overflow_err},
                         {m_cnt != DEPTH, m_v, m_ovf});
            end
            n_cmp++;
            if ({fetch_ready0, out_valid0, overflow_err0} !== {m_cnt != DEPTH, m_v, m_ovf}) begin
                n_err++;
                $display("FAIL status_nochk got=%b exp=%b", {fetch_ready0, out_valid0, overflow_err0},
                         {m_cnt != DEPTH, m_v, m_ovf});
            end
            if (m_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL slot_fields got=pc %h exp=nothing queued", out_pc);
                end else begin
                    e    = exp_q[0];
                    exp  = ref_fields(e[63:32], e[31:0]);
                    got  = {out_pc, out_inst, out_opcode, out_funct3, out_funct7, out_rs1_s,
                            out_rs2_s, out_rd_s, out_i_imm, out_s_imm, out_b_imm, out_u_imm,
                            out_j_imm, out_illegal};
                    got0 = {out_pc0, out_inst0, out_opcode0, out_funct30, out_funct70, out_rs1_s0,
                            out_rs2_s0, out_rd_s0, out_i_imm0, out_s_imm0, out_b_imm0, out_u_imm0,
                            out_j_imm0, out_illegal0};
                    n_cmp++;
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL slot_fields got=%h exp=%h", got, exp);
                    end
                    n_cmp++;
                    if (got0 !== {exp[256:1], 1'b0}) begin
                        n_err++;
                        $display("FAIL slot_fields_nochk got=%h exp=%h", got0, {exp[256:1], 1'b0});
                    end
                    if (ex_ready && !flush) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (flush) begin
                exp_q.delete();
                m_cnt = 0;
                m_v   = 1'b0;
            end else begin
                rdy = (m_cnt != DEPTH);
                ld  = (m_cnt != 0) && (!m_v || ex_ready);
                acc = imem_resp && rdy;
                if (imem_resp && !rdy) m_ovf = 1'b1;
                if (acc) exp_q.push_back({fetch_pc, imem_rdata});
                m_cnt = m_cnt + int'(acc) - int'(ld);
                if (ld) m_v = 1'b1;
                else if (ex_ready) m_v = 1'b0;
            end
        end else begin
            exp_q.delete();
            m_cnt = 0;
            m_v   = 1'b0;
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        imem_resp = 1'b0;
        flush     = 1'b0;
        ex_ready  = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || m_v) && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout got=left %0d valid %b exp=left 0 valid 0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_resp = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        imem_rdata = 32'h0; fetch_pc = 32'h0;
        tick();
        tick();
        n_cmp++;
        if ({fetch_ready, out_valid, overflow_err, out_illegal} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_status got=%b exp=1000", {fetch_ready, out_valid, overflow_err, out_illegal});
        end
        n_cmp++;
        if ({out_pc, out_inst, out_i_imm, out_j_imm} !== 128'h0) begin
            n_err++;
            $display("FAIL reset_fields got=%h exp=0", {out_pc, out_inst, out_i_imm, out_j_imm});
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        ex_ready = 1'b1; imem_resp = 1'b1; fetch_pc = 32'h1000; imem_rdata = 32'h0050_0093;
        tick();
        imem_resp = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early got=%b exp=0", out_valid);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_rd_s, out_rs1_s, out_opcode, out_illegal} !== {1'b1, 5'd1, 5'd0, 7'h13, 1'b0}) begin
            n_err++;
            $display("FAIL single_fields got=%b/%0d/%0d/%h/%b exp=1/1/0/13/0",
                     out_valid, out_rd_s, out_rs1_s, out_opcode, out_illegal);
        end
        n_cmp++;
        if ({out_pc, out_i_imm} !== {32'h1000, 32'd5}) begin
            n_err++;
            $display("FAIL single_pc_imm got=%h %h exp=00001000 00000005", out_pc, out_i_imm);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_consumed got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_branch_jal();
        ex_ready = 1'b1; imem_resp = 1'b1; fetch_pc = 32'h2000; imem_rdata = 32'hFE00_0EE3;
        tick();
        fetch_pc = 32'h2004; imem_rdata = 32'h8000_00EF;
        tick();
        imem_resp = 1'b0;
        n_cmp++;
        if (out_b_imm !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL beq_b_imm got=%h exp=fffffffc", out_b_imm);
        end
        tick();
        n_cmp++;
        if (out_j_imm !== 32'hFFF0_0000) begin
            n_err++;
            $display("FAIL jal_j_imm got=%h exp=fff00000", out_j_imm);
        end
        drain(8);
    endtask

    task automatic test_stream();
        ex_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h3000 + 32'(4 * i); imem_rdata = rand_inst();
            tick();
            if (i >= 1) begin
                n_cmp++;
                if ({out_valid, out_pc} !== {1'b1, 32'h3000 + 32'(4 * (i - 1))}) begin
                    n_err++;
                    $display("FAIL stream_rate got=%b %h exp=1 %h", out_valid, out_pc,
                             32'h3000 + 32'(4 * (i - 1)));
                end
            end
        end
        imem_resp = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h4000 + 32'(4 * i); imem_rdata = rand_inst();
            tick();
        end
        fetch_pc = 32'h4100; flush = 1'b1;
        tick();
        flush = 1'b0; imem_resp = 1'b0;
        n_cmp++;
        if ({out_valid, fetch_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_state got=%b exp=01", {out_valid, fetch_ready});
        end
        imem_resp = 1'b1; ex_ready = 1'b1; fetch_pc = 32'h4200; imem_rdata = 32'h0000_0013;
        tick();
        imem_resp = 1'b0;
        tick();
        n_cmp++;
        if ({out_valid, out_pc} !== {1'b1, 32'h4200}) begin
            n_err++;
            $display("FAIL flush_next got=%b %h exp=1 00004200", out_valid, out_pc);
        end
        tick();
        // Fill slot and queue completely, then flush alongside a response.
        ex_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h4300 + 32'(4 * i); imem_rdata = rand_inst();
            tick();
        end
        n_cmp++;
        if (fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_fill got=%b exp=0", fetch_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; imem_resp = 1'b0;
        n_cmp++;
        if ({overflow_err, fetch_ready, out_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL flush_full got=%b exp=010", {overflow_err, fetch_ready, out_valid});
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [4];
        logic        ill   [4];
        words = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0073, 32'h0000_005B};
        ill   = '{1'b1, 1'b1, 1'b0, 1'b1};
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h5000 + 32'(4 * i); imem_rdata = words[i];
            tick();
            imem_resp = 1'b0;
            tick();
            n_cmp++;
            if ({out_valid, out_illegal, out_illegal0} !== {1'b1, ill[i], 1'b0}) begin
                n_err++;
                $display("FAIL illegal_%h got=%b exp=%b", words[i],
                         {out_valid, out_illegal, out_illegal0}, {1'b1, ill[i], 1'b0});
            end
            tick();
        end
        for (int i = 0; i < 24; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h5100 + 32'(4 * i); imem_rdata = rand_inst();
            tick();
        end
        drain(8);
    endtask

    task automatic test_overflow();
        int start;
        ex_ready = 1'b0; imem_resp = 1'b1; fetch_pc = 32'h6000; imem_rdata = rand_inst();
        tick();
        imem_resp = 1'b0;
        tick();
        for (int i = 0; i <= DEPTH; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h6100 + 32'(4 * i); imem_rdata = rand_inst();
            tick();
            if (i == DEPTH - 1) begin
                n_cmp++;
                if ({fetch_ready, overflow_err} !== 2'b00) begin
                    n_err++;
                    $display("FAIL ovf_full got=%b exp=00", {fetch_ready, overflow_err});
                end
            end
        end
        imem_resp = 1'b0;
        n_cmp++;
        if ({overflow_err, out_pc} !== {1'b1, 32'h6000}) begin
            n_err++;
            $display("FAIL ovf_sticky got=%b %h exp=1 00006000", overflow_err, out_pc);
        end
        repeat (3) tick();
        start = n_out;
        drain(4 * DEPTH);
        n_cmp++;
        if (n_out - start !== DEPTH + 1) begin
            n_err++;
            $display("FAIL ovf_outputs got=%0d exp=%0d", n_out - start, DEPTH + 1);
        end
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            imem_resp = 1'b1; fetch_pc = 32'h7000 + 32'(4 * i); imem_rdata = rand_inst();
            tick();
        end
        imem_resp = 1'b0;
        tick();
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, overflow_err, fetch_ready, out_pc} !== {3'b001, 32'h0}) begin
            n_err++;
            $display("FAIL async_reset got=%b %h exp=001 00000000",
                     {out_valid, overflow_err, fetch_ready}, out_pc);
        end
        tick();
        tick();
        rst = 1'b1;
        imem_resp = 1'b1; ex_ready = 1'b1; fetch_pc = 32'h7100; imem_rdata = 32'h0000_0037;
        tick();
        imem_resp = 1'b0;
        tick();
        n_cmp++;
        if ({out_valid, out_pc} !== {1'b1, 32'h7100}) begin
            n_err++;
            $display("FAIL after_reset got=%b %h exp=1 00007100", out_valid, out_pc);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            imem_resp  = 1'($urandom_range(0, 1));
            ex_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            fetch_pc   = 32'h8000 + 32'(4 * i);
            imem_rdata = rand_inst();
            tick();
        end
        drain(4 * DEPTH);
    endtask

    initial begin
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h5B};
        test_reset();
        test_single();
        test_branch_jal();
        test_stream();
        test_flush();
        test_illegal();
        test_overflow();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_queue_stage.md
Name: id_queue_stage

Overview:
- Decode stage with a parametrised instruction queue between the imem response and EX.
- Buffers up to DEPTH fetched {pc, inst} pairs and decodes the head into a registered output slot.
- Handshakes valid/ready with EX so the downstream stage can stall; supports pipeline flush and optional illegal-opcode detection.
- Replaces the purely combinational decode path in the RV32I pipeline.

Parameters:
- DEPTH, 4, queue entries; power of two, 2 to 16.
- ILLEGAL_CHECK, 1, 1 = drive out_illegal from opcode legality; 0 = tie out_illegal to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- imem_rdata  in  32  fetched instruction.
- imem_resp  in  1  imem_rdata/fetch_pc valid this cycle.
- fetch_pc  in  32  PC of the instruction on imem_rdata.
- fetch_ready  out  1  queue can accept a response next edge.
- flush  in  1  synchronous kill of all buffered/decoded instructions.
- ex_ready  in  1  EX accepts the output slot this cycle.
- out_valid  out  1  output slot holds a decoded instruction.
- out_pc, out_inst  out  32 each  PC and raw instruction.
- out_opcode 7, out_funct3 3, out_funct7 7, out_rs1_s 5, out_rs2_s 5, out_rd_s 5  out  decoded fields (inst[6:0], [14:12], [31:25], [19:15], [24:20], [11:7]).
- out_i_imm, out_s_imm, out_b_imm, out_u_imm, out_j_imm  out  32 each  sign-extended immediates, standard RV32I bit layout (b/j LSB = 0, u low 12 bits = 0).
- out_illegal  out  1  decoded instruction is not a legal RV32I encoding.
- overflow_err  out  1  sticky: imem_resp arrived while queue was full.

Behaviour:
- Reset (rst low, async): head/tail pointers, count, out_valid, all out_* fields, overflow_err = 0. While held in reset, fetch_ready = 1.
- fetch_ready = (count != DEPTH); combinational from count only, no dependence on same-cycle pop.
- Push: on the edge where imem_resp && fetch_ready && !flush, write {fetch_pc, imem_rdata} at tail; tail wraps modulo DEPTH.
- imem_resp && !fetch_ready && !flush: data dropped, count unchanged, overflow_err set and held until reset.
- Slot load condition: load = !empty && (!out_valid || ex_ready) && !flush.
- On load: pop the head, decode, and register every out_* field; set out_valid = 1.
- out_valid && ex_ready with queue empty: out_valid clears.
- out_valid && !ex_ready: all out_* held bit-stable.
- Simultaneous push and pop: count unchanged. A pop does not free a slot for a same-edge push when full.
- Latency: response pushed at edge N into an empty queue with an empty slot gives out_valid = 1 after edge N+1.
- Throughput: one instruction per cycle sustained when ex_ready = 1.
- flush has priority over push, pop and load. On that edge:
  - count = 0; head = tail = 0; out_valid = 0.
  - Same-cycle imem_resp ignored and does not set overflow_err.
  - out_* data fields may hold stale values.
- Counter width clog2(DEPTH+1); count never exceeds DEPTH or underflows.
- out_illegal (ILLEGAL_CHECK=1) = 1 when inst[1:0] != 2'b11, or opcode is not one of: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Funct fields are not checked.
- Reset asserted mid-operation discards all contents immediately, with no dependence on clk.

Test Plan:
- Reset, then single push of 32'h00500093 (addi x1,x0,5) pc 32'h1000, ex_ready=1 -> out_valid=1 one edge after push; rd_s=1, rs1_s=0, i_imm=5, opcode=7'h13, out_pc=32'h1000, out_illegal=0.
- Push 32'hFE000EE3 (beq x0,x0,-4), ex_ready=1 -> out_b_imm=32'hFFFFFFFC; then 32'h800000EF (jal) -> out_j_imm=32'hFFF00000.
- ex_ready=0, push DEPTH+1 responses while slot is full -> fetch_ready falls once DEPTH entries are queued; extra response sets overflow_err=1. Release ex_ready -> DEPTH+1 in-order outputs (slot plus queue), out_* stable during stall.
- Continuous push with ex_ready=1 for 20 cycles -> one output per cycle, correct pc order, count never exceeds 1.
- Queue holding 3 entries plus imem_resp and flush in the same cycle -> next cycle out_valid=0, fetch_ready=1; next push emerges first with its own pc.
- Push 32'h00000000 and 32'hFFFFFFFF -> out_illegal=1 with ILLEGAL_CHECK=1, 0 with ILLEGAL_CHECK=0. Drop rst mid-stream -> out_valid=0, overflow_err=0 without a clock edge.
